// File: rtl/glitch_free_div_sel.sv
// glitch_free_div_sel: programmable 50%-duty clock divider whose ratio can
// change, stop and restart without producing runt phases on clk_out.
// Ratio changes, stops and restarts happen only at the rise point, meaning
// the last cycle of a low phase.
// Optional build macro GLITCH_FREE_DIV_SEL_SYNC_EN adds 2-flop synchronisers
// on en and sel, for use when they come from another clock domain.
//
// state | meaning
// RUN   | dividing at cur_sel, no change requested
// PEND  | sel_s differs from cur_sel, waiting for the rise point to commit
// STOP  | clk_out parked low, waiting for en
module glitch_free_div_sel #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             clk_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             switch_done
);

  typedef enum logic [1:0] {RUN, PEND, STOP} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] cnt, cnt_nxt, cur_sel_nxt;
  logic             clk_out_nxt, switch_done_nxt, busy_nxt;
  logic [SEL_W-1:0] sel_s;
  logic             en_s;
  logic             at_end, rise_pt, sel_diff;

`ifdef GLITCH_FREE_DIV_SEL_SYNC_EN
  logic [SEL_W-1:0] sel_m;
  logic             en_m;

  // two-flop synchronisers for the control inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m <= '0;
      sel_s <= '0;
      en_m  <= 1'b0;
      en_s  <= 1'b0;
    end else begin
      sel_m <= sel;
      sel_s <= sel_m;
      en_m  <= en;
      en_s  <= en_m;
    end
  end
`else
  assign sel_s = sel;
  assign en_s  = en;
`endif

  assign at_end   = (cnt == cur_sel);
  assign rise_pt  = !clk_out && at_end;
  assign sel_diff = (sel_s != cur_sel);

  // next-state, counter and output-clock decisions
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    clk_out_nxt     = clk_out;
    cur_sel_nxt     = cur_sel;
    switch_done_nxt = 1'b0;
    unique case (state)
      STOP: begin
        clk_out_nxt = 1'b0;
        cnt_nxt     = '0;
        if (en_s) begin
          clk_out_nxt     = 1'b1;
          cur_sel_nxt     = sel_s;
          switch_done_nxt = sel_diff;
          state_nxt       = RUN;
        end
      end
      RUN, PEND: begin
        if (rise_pt && !en_s) begin
          // stop wins over any pending ratio change; the change is picked up at restart
          clk_out_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = STOP;
        end else if (rise_pt && (state == PEND)) begin
          clk_out_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = RUN;
          if (sel_diff) begin
            cur_sel_nxt     = sel_s;
            switch_done_nxt = 1'b1;
          end
        end else begin
          if (at_end) begin
            cnt_nxt     = '0;
            clk_out_nxt = !clk_out;
          end else begin
            cnt_nxt = cnt + SEL_W'(1);
          end
          if ((state == RUN) && sel_diff) state_nxt = PEND;
        end
      end
      default: begin
        state_nxt   = STOP;
        clk_out_nxt = 1'b0;
        cnt_nxt     = '0;
      end
    endcase
    busy_nxt = (state_nxt == PEND);
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STOP;
      cnt         <= '0;
      clk_out     <= 1'b0;
      cur_sel     <= '0;
      busy        <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      clk_out     <= clk_out_nxt;
      cur_sel     <= cur_sel_nxt;
      busy        <= busy_nxt;
      switch_done <= switch_done_nxt;
    end
  end

endmodule
